// File: rtl/dff_arb_pkg.sv
// Shared types and configuration checks for the shared-register round-robin arbiter.
package dff_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_e;

    localparam int MIN_NUM_REQ   = 2;
    localparam int MIN_MAX_BURST = 1;

    function automatic bit cfg_ok(input int num_req, input int max_burst);
        return (num_req >= MIN_NUM_REQ) && (max_burst >= MIN_MAX_BURST);
    endfunction

endpackage

// File: rtl/dff_bank_arbiter_rr_picker.sv
// Combinational round-robin pick: first set req bit at or after start, wrapping modulo NUM_REQ.
module rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] start,
    output logic                       vld,
    output logic [$clog2(NUM_REQ)-1:0] idx
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] c;

    always_comb begin
        vld = 1'b0;
        idx = '0;
        c   = start;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!vld && req[c]) begin
                vld = 1'b1;
                idx = c;
            end
            // explicit wrap keeps non-power-of-two NUM_REQ in range
            c = (c == IW'(NUM_REQ - 1)) ? '0 : c + IW'(1);
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin owner of one shared WIDTH-bit register; the grantee writes its lane each cycle
// for up to MAX_BURST writes, then ownership passes on without an idle bubble.
module dff_bank_arbiter
    import dff_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   wdata,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy,
    output logic [WIDTH-1:0]           q
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    if (!cfg_ok(NUM_REQ, MAX_BURST)) begin : g_bad_cfg
        $error("dff_bank_arbiter: need NUM_REQ >= 2 and MAX_BURST >= 1");
    end

    arb_state_e        state, state_n;
    logic [NUM_REQ-1:0] gnt_n;
    logic [IW-1:0]     owner_n, ptr, ptr_n, pick_start, pick_idx;
    logic [CW-1:0]     cnt, cnt_n;
    logic [WIDTH-1:0]  q_n;
    logic              pick_vld, wr, last;
    logic [WIDTH-1:0]  lane [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign lane[i] = wdata[i*WIDTH +: WIDTH];
    end

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        return (v == IW'(NUM_REQ - 1)) ? '0 : v + IW'(1);
    endfunction

    // one picker: start after the owner while owning, after the pointer while idle
    assign pick_start = (state == ARB_OWN) ? wrap_inc(owner) : wrap_inc(ptr);

    rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (req),
        .start (pick_start),
        .vld   (pick_vld),
        .idx   (pick_idx)
    );

    assign wr   = (state == ARB_OWN) && req[owner];
    assign last = wr && (cnt == CW'(MAX_BURST - 1));
    assign busy = |gnt;

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        owner_n = owner;
        ptr_n   = ptr;
        cnt_n   = cnt;
        q_n     = q;
        if (wr) begin
            q_n   = lane[owner];
            cnt_n = cnt + CW'(1);
        end
        case (state)
            ARB_IDLE: begin
                if (pick_vld) begin
                    state_n         = ARB_OWN;
                    gnt_n           = '0;
                    gnt_n[pick_idx] = 1'b1;
                    owner_n         = pick_idx;
                    ptr_n           = pick_idx;
                    cnt_n           = '0;
                end
            end
            ARB_OWN: begin
                if (!req[owner] || last) begin
                    cnt_n = '0;
                    if (pick_vld) begin
                        gnt_n           = '0;
                        gnt_n[pick_idx] = 1'b1;
                        owner_n         = pick_idx;
                        ptr_n           = pick_idx;
                    end else begin
                        state_n = ARB_IDLE;
                        gnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = ARB_IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
            gnt   <= '0;
            owner <= '0;
            ptr   <= IW'(NUM_REQ - 1);
            cnt   <= '0;
            q     <= '0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            owner <= owner_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            q     <= q_n;
        end
    end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed vectors plus hand sequences for contention and lone re-grant on dff_bank_arbiter.
module tb_dff_bank_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  q;

    int total = 0;
    int bad   = 0;

    dff_bank_arbiter #(.NUM_REQ(4), .WIDTH(8), .MAX_BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .wdata (wdata),
        .gnt   (gnt),
        .owner (owner),
        .busy  (busy),
        .q     (q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        logic [1:0]  owner;
        logic        busy;
        logic [7:0]  q;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] rq, input logic [31:0] wd);
        reset = r;
        req   = rq;
        wdata = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic [31:0] wd,
                       input logic [3:0] g, input logic [1:0] o, input logic b, input logic [7:0] qq);
        vec_t v;
        v.rst = r; v.req = rq; v.wdata = wd; v.gnt = g; v.owner = o; v.busy = b; v.q = qq;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req = '0; wdata = '0;
        // single requester, no burst
        add(1, 4'b0000, 32'h0,         4'b0000, 2'd0, 0, 8'h00);
        add(0, 4'b0100, 32'h00A5_0000, 4'b0100, 2'd2, 1, 8'h00);
        add(0, 4'b0100, 32'h00A5_0000, 4'b0100, 2'd2, 1, 8'hA5);
        add(0, 4'b0000, 32'h0,         4'b0000, 2'd2, 0, 8'hA5);
        add(0, 4'b0000, 32'h0,         4'b0000, 2'd2, 0, 8'hA5);
        // early release: owner 3 writes 11, 22 then drops while req[0] high
        add(0, 4'b1000, 32'h0,         4'b1000, 2'd3, 1, 8'hA5);
        add(0, 4'b1000, 32'h1100_0000, 4'b1000, 2'd3, 1, 8'h11);
        add(0, 4'b1001, 32'h2200_0000, 4'b1000, 2'd3, 1, 8'h22);
        add(0, 4'b0001, 32'h0000_0077, 4'b0001, 2'd0, 1, 8'h22);
        add(0, 4'b0001, 32'h0000_0033, 4'b0001, 2'd0, 1, 8'h33);
        add(0, 4'b0000, 32'h0,         4'b0000, 2'd0, 0, 8'h33);
        // reset during owner 2's second write
        add(0, 4'b0100, 32'h0,         4'b0100, 2'd2, 1, 8'h33);
        add(0, 4'b0100, 32'h0044_0000, 4'b0100, 2'd2, 1, 8'h44);
        add(1, 4'b0100, 32'h0055_0000, 4'b0000, 2'd0, 0, 8'h00);
        add(0, 4'b1010, 32'h0,         4'b0010, 2'd1, 1, 8'h00);
        // owner 1 completes its burst; then 0 wins over the just-finished 1
        add(0, 4'b0010, 32'h0000_0100, 4'b0010, 2'd1, 1, 8'h01);
        add(0, 4'b0010, 32'h0000_0200, 4'b0010, 2'd1, 1, 8'h02);
        add(0, 4'b0010, 32'h0000_0300, 4'b0010, 2'd1, 1, 8'h03);
        add(0, 4'b0011, 32'h0000_0400, 4'b0001, 2'd0, 1, 8'h04);
        add(0, 4'b0011, 32'h0000_050A, 4'b0001, 2'd0, 1, 8'h0A);
        add(0, 4'b0000, 32'h0,         4'b0000, 2'd0, 0, 8'h0A);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].wdata);
            chk($sformatf("v%0d.gnt", i),   32'(gnt),   32'(vecs[i].gnt));
            chk($sformatf("v%0d.owner", i), 32'(owner), 32'(vecs[i].owner));
            chk($sformatf("v%0d.busy", i),  32'(busy),  32'(vecs[i].busy));
            chk($sformatf("v%0d.q", i),     32'(q),     32'(vecs[i].q));
        end

        // full contention: lane i drives i+n before edge n; owner after edge n is (n/4)%4
        step(1, 4'b0000, 32'h0);
        for (int n = 0; n <= 20; n++) begin
            logic [31:0] wd;
            logic [3:0]  eg;
            for (int i = 0; i < 4; i++) wd[i*8 +: 8] = 8'(i + n);
            step(0, 4'b1111, wd);
            eg = 4'b0001 << ((n / 4) % 4);
            chk($sformatf("cont%0d.gnt", n), 32'(gnt), 32'(eg));
            chk($sformatf("cont%0d.busy", n), 32'(busy), 32'd1);
            if (n > 0)
                chk($sformatf("cont%0d.q", n), 32'(q), 32'((((n - 1) / 4) % 4) + n));
        end

        // lone requester re-granted back-to-back, writing every cycle
        step(1, 4'b0000, 32'h0);
        begin
            int writes;
            logic [7:0] prev;
            writes = 0;
            prev = q;
            for (int n = 0; n < 10; n++) begin
                step(0, 4'b0010, {16'h0, 8'(8'h50 + n), 8'h0});
                chk($sformatf("lone%0d.gnt", n), 32'(gnt), 32'h2);
                if (q != prev) writes++;
                prev = q;
                if (n > 0) chk($sformatf("lone%0d.q", n), 32'(q), 32'(8'h50 + n));
            end
            chk("lone.writes", 32'(writes), 32'd9);
            step(0, 4'b0000, 32'h0);
            chk("lone.drop.gnt", 32'(gnt), 32'h0);
            chk("lone.drop.q", 32'(q), 32'h59);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
